falafel_alloc_ctrl: RTL and testbench

First-fit allocation controller for the falafel free-list allocator. It accepts one allocation request at a time and walks the singly linked free list through the header LSU (`header_req_t` / `header_rsp_t`), locking the list for the whole walk. It either splits or takes the first block that fits, relinks the list, and returns the payload address. It sits between the allocator front end and the header LSU.

---
 rtl/falafel_alloc_ctrl.sv | 162 ++++++++++++++++
 tb/tb_falafel_alloc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_alloc_ctrl.sv
// falafel_alloc_ctrl: first-fit free-list allocation controller driving the header LSU
package falafel_pkg;
    localparam int DATA_W = 64;
    localparam logic [DATA_W-1:0] BLOCK_HEADER_SIZE = 64'd16;
    localparam logic [DATA_W-1:0] MIN_ALLOC_SIZE = 64'd16;
    localparam logic [DATA_W-1:0] EMPTY_KEY = '0;
    typedef enum logic [2:0] {
        OP_LOCK,
        OP_UNLOCK,
        OP_LOAD,
        OP_EDIT_SIZE_AND_NEXT_ADDR,
        OP_EDIT_NEXT_ADDR
    } header_op_e;
    typedef struct packed {
        logic val;
        header_op_e op;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_req_t;
    typedef struct packed {
        logic val;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] next_addr;
    } header_rsp_t;
endpackage

module falafel_alloc_ctrl
    import falafel_pkg::*;
#(
    parameter logic [DATA_W-1:0] FREE_LIST_HEAD_ADDR = 64'h1000,
    parameter int unsigned MAX_HOPS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_req_valid_i,
    output logic              alloc_req_ready_o,
    input  logic [DATA_W-1:0] alloc_req_size_i,
    output logic              alloc_rsp_valid_o,
    input  logic              alloc_rsp_ready_i,
    output logic [DATA_W-1:0] alloc_rsp_addr_o,
    output logic              alloc_rsp_ok_o,
    output header_req_t       lsu_req_o,
    input  logic              lsu_req_ready_i,
    input  header_rsp_t       lsu_rsp_i
);
    localparam int HW = $clog2(MAX_HOPS + 1);
    localparam logic [DATA_W-1:0] SIZE_LIMIT = {DATA_W{1'b1}} - (BLOCK_HEADER_SIZE + 64'd7);
    typedef enum logic [3:0] {
        IDLE, LOCK, LOAD_HEAD, CHECK, LOAD_CUR, WR_SPLIT, WR_ALLOC, WR_PREV, UNLOCK, RESP
    } state_e;
    state_e state;
    logic busy, fail, issuing, done;
    logic [DATA_W-1:0] req, cur_addr, cur_size, cur_next, prev_addr, link, rounded, req_blk;
    logic [HW-1:0] hops;
    header_req_t issue;

    assign alloc_req_ready_o = state == IDLE;
    assign issuing = state inside {LOCK, LOAD_HEAD, LOAD_CUR, WR_SPLIT, WR_ALLOC, WR_PREV, UNLOCK};
    assign done = busy & lsu_rsp_i.val & (~lsu_req_o.val | lsu_req_ready_i);
    assign rounded = (alloc_req_size_i + BLOCK_HEADER_SIZE + 64'd7) & ~64'd7;
    assign req_blk = rounded < MIN_ALLOC_SIZE ? MIN_ALLOC_SIZE : rounded;

    always_comb begin
        issue = '0;
        issue.val = 1'b1;
        issue.op = state == LOCK ? OP_LOCK : state == UNLOCK ? OP_UNLOCK :
                   state inside {LOAD_HEAD, LOAD_CUR} ? OP_LOAD :
                   state == WR_PREV ? OP_EDIT_NEXT_ADDR : OP_EDIT_SIZE_AND_NEXT_ADDR;
        issue.addr = state inside {LOCK, UNLOCK, LOAD_HEAD} ? FREE_LIST_HEAD_ADDR :
                     state == WR_SPLIT ? cur_addr + req : state == WR_PREV ? prev_addr : cur_addr;
        issue.size = state == WR_SPLIT ? cur_size - req : state == WR_ALLOC ? req : '0;
        issue.next_addr = state == WR_SPLIT ? cur_next : state == WR_PREV ? link : EMPTY_KEY;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            busy <= 1'b0;
            fail <= 1'b0;
            req <= '0;
            cur_addr <= '0;
            cur_size <= '0;
            cur_next <= '0;
            prev_addr <= '0;
            link <= '0;
            hops <= '0;
            lsu_req_o <= '0;
            alloc_rsp_valid_o <= 1'b0;
            alloc_rsp_addr_o <= '0;
            alloc_rsp_ok_o <= 1'b0;
        end else begin
            if (issuing && !busy) begin
                lsu_req_o <= issue;
                busy <= 1'b1;
            end else if (lsu_req_o.val && lsu_req_ready_i) begin
                lsu_req_o.val <= 1'b0;
            end
            if (done) busy <= 1'b0;
            case (state)
                IDLE: if (alloc_req_valid_i) begin
                    req <= req_blk;
                    fail <= 1'b0;
                    if (alloc_req_size_i > SIZE_LIMIT) begin
                        alloc_rsp_valid_o <= 1'b1;
                        alloc_rsp_ok_o <= 1'b0;
                        alloc_rsp_addr_o <= '0;
                        state <= RESP;
                    end else begin
                        state <= LOCK;
                    end
                end
                LOCK: if (done) state <= LOAD_HEAD;
                LOAD_HEAD: if (done) begin
                    prev_addr <= FREE_LIST_HEAD_ADDR;
                    cur_addr <= lsu_rsp_i.next_addr;
                    hops <= '0;
                    state <= CHECK;
                end
                CHECK: if (cur_addr == EMPTY_KEY || hops == HW'(MAX_HOPS)) begin
                    fail <= 1'b1;
                    state <= UNLOCK;
                end else begin
                    state <= LOAD_CUR;
                end
                LOAD_CUR: if (done) begin
                    hops <= hops + HW'(1);
                    cur_size <= lsu_rsp_i.size;
                    cur_next <= lsu_rsp_i.next_addr;
                    if (lsu_rsp_i.size < req) begin
                        prev_addr <= cur_addr;
                        cur_addr <= lsu_rsp_i.next_addr;
                        state <= CHECK;
                    end else if (lsu_rsp_i.size - req >= MIN_ALLOC_SIZE) begin
                        state <= WR_SPLIT;
                    end else begin
                        req <= lsu_rsp_i.size;
                        link <= lsu_rsp_i.next_addr;
                        state <= WR_ALLOC;
                    end
                end
                WR_SPLIT: if (done) begin
                    link <= cur_addr + req;
                    state <= WR_ALLOC;
                end
                WR_ALLOC: if (done) state <= WR_PREV;
                WR_PREV: if (done) state <= UNLOCK;
                UNLOCK: if (done) begin
                    alloc_rsp_valid_o <= 1'b1;
                    alloc_rsp_ok_o <= ~fail;
                    alloc_rsp_addr_o <= fail ? '0 : cur_addr + BLOCK_HEADER_SIZE;
                    state <= RESP;
                end
                RESP: if (alloc_rsp_ready_i) begin
                    alloc_rsp_valid_o <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_falafel_alloc_ctrl.sv
// tb_falafel_alloc_ctrl: directed bench with a header-memory LSU model for falafel_alloc_ctrl
module tb_falafel_alloc_ctrl;
    import falafel_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, rsp_ready = 1'b0;
    logic [63:0] req_size = '0;
    logic req_ready, rsp_valid, rsp_ok, lsu_ready;
    logic [63:0] rsp_addr;
    header_req_t lsu_req;
    header_rsp_t lsu_rsp;
    int tests = 0, fails = 0, base = 0, ld = 0, stall_op = -1;
    logic dly = 1'b0;
    logic [63:0] ia [8], is [8], in [8];
    logic [63:0] ma [8], ms [8], mn [8];
    header_req_t log_q [$];
    int n_ops = 0, ld_seen = 0, stalled = 0, k, kw;
    logic pend = 1'b0;
    logic [63:0] pend_sz = '0, pend_nx = '0;

    always #5 clk = ~clk;

    falafel_alloc_ctrl #(.MAX_HOPS(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_req_valid_i(req_valid), .alloc_req_ready_o(req_ready), .alloc_req_size_i(req_size),
        .alloc_rsp_valid_o(rsp_valid), .alloc_rsp_ready_i(rsp_ready),
        .alloc_rsp_addr_o(rsp_addr), .alloc_rsp_ok_o(rsp_ok),
        .lsu_req_o(lsu_req), .lsu_req_ready_i(lsu_ready), .lsu_rsp_i(lsu_rsp)
    );

    function automatic int find(input logic [63:0] a);
        for (int i = 0; i < 8; i++) if (ma[i] == a) return i;
        return -1;
    endfunction

    assign lsu_ready = !(n_ops == stall_op && stalled < 3);

    always_comb begin
        k = find(lsu_req.addr);
        kw = k < 0 ? find(64'd0) : k;
        lsu_rsp = '0;
        lsu_rsp.val = dly ? pend : (lsu_req.val && lsu_ready);
        lsu_rsp.size = dly ? pend_sz : (k < 0 ? 64'd0 : ms[k]);
        lsu_rsp.next_addr = dly ? pend_nx : (k < 0 ? 64'd0 : mn[k]);
    end

    always @(posedge clk) begin
        pend <= 1'b0;
        if (lsu_req.val && !lsu_ready) stalled <= stalled + 1;
        if (lsu_req.val && lsu_ready) begin
            log_q.push_back(lsu_req);
            n_ops <= n_ops + 1;
            pend <= 1'b1;
            pend_sz <= k < 0 ? 64'd0 : ms[k];
            pend_nx <= k < 0 ? 64'd0 : mn[k];
            if ((lsu_req.op == OP_EDIT_SIZE_AND_NEXT_ADDR || lsu_req.op == OP_EDIT_NEXT_ADDR) && kw >= 0) begin
                ma[kw] <= lsu_req.addr;
                mn[kw] <= lsu_req.next_addr;
                if (lsu_req.op == OP_EDIT_SIZE_AND_NEXT_ADDR) ms[kw] <= lsu_req.size;
            end
        end else if (ld != ld_seen) begin
            ma <= ia;
            ms <= is;
            mn <= in;
            ld_seen <= ld;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_op(input string tag, input int i, input header_op_e op,
                          input logic [63:0] a, input logic [63:0] s, input logic [63:0] n);
        header_req_t e, g;
        e.val = 1'b1;
        e.op = op;
        e.addr = a;
        e.size = s;
        e.next_addr = n;
        g = '0;
        if (base + i < log_q.size()) g = log_q[base + i];
        tests++;
        assert (g === e) else begin
            fails++;
            $error("FAIL %s op%0d got=%0d/%h/%h/%h exp=%0d/%h/%h/%h", tag, i,
                   g.op, g.addr, g.size, g.next_addr, e.op, e.addr, e.size, e.next_addr);
        end
    endtask

    task automatic setup(input logic [63:0] hn,
                         input logic [63:0] a1, input logic [63:0] s1, input logic [63:0] n1,
                         input logic [63:0] a2, input logic [63:0] s2, input logic [63:0] n2,
                         input logic [63:0] a3, input logic [63:0] s3, input logic [63:0] n3);
        for (int i = 0; i < 8; i++) begin
            ia[i] = '0;
            is[i] = '0;
            in[i] = '0;
        end
        ia[0] = 64'h1000; in[0] = hn;
        ia[1] = a1; is[1] = s1; in[1] = n1;
        ia[2] = a2; is[2] = s2; in[2] = n2;
        ia[3] = a3; is[3] = s3; in[3] = n3;
        ld++;
        @(posedge clk);
        @(negedge clk);
        base = n_ops;
    endtask

    task automatic send(input logic [63:0] sz);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        req_valid = 1'b1;
        req_size = sz;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    endtask

    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, t, n_before;
        header_req_t snap;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_addr", rsp_addr, 64'd0);
        chk("rst_rsp_ok", 64'(rsp_ok), 64'd0);
        chk("rst_lsu_val", 64'(lsu_req.val), 64'd0);
        rst_n = 1'b1;

        setup(64'h2000, 64'h2000, 64'h100, 64'h0, 0, 0, 0, 0, 0, 0);
        send(64'h20);
        wait_rsp("split", lat);
        repeat (2) @(negedge clk);
        chk("split_hold_valid", 64'(rsp_valid), 64'd1);
        chk("split_ok", 64'(rsp_ok), 64'd1);
        chk("split_addr", rsp_addr, 64'h2010);
        take_rsp();
        chk("split_nops", 64'(n_ops - base), 64'd7);
        chk_op("split", 0, OP_LOCK, 64'h1000, 0, 0);
        chk_op("split", 1, OP_LOAD, 64'h1000, 0, 0);
        chk_op("split", 2, OP_LOAD, 64'h2000, 0, 0);
        chk_op("split", 3, OP_EDIT_SIZE_AND_NEXT_ADDR, 64'h2030, 64'hD0, 0);
        chk_op("split", 4, OP_EDIT_SIZE_AND_NEXT_ADDR, 64'h2000, 64'h30, 0);
        chk_op("split", 5, OP_EDIT_NEXT_ADDR, 64'h1000, 0, 64'h2030);
        chk_op("split", 6, OP_UNLOCK, 64'h1000, 0, 0);

        dly = 1'b1;
        setup(64'h2000, 64'h2000, 64'h30, 64'h5000, 0, 0, 0, 0, 0, 0);
        send(64'h18);
        wait_rsp("nosplit", lat);
        chk("nosplit_ok", 64'(rsp_ok), 64'd1);
        chk("nosplit_addr", rsp_addr, 64'h2010);
        take_rsp();
        chk("nosplit_nops", 64'(n_ops - base), 64'd6);
        chk_op("nosplit", 3, OP_EDIT_SIZE_AND_NEXT_ADDR, 64'h2000, 64'h30, 0);
        chk_op("nosplit", 4, OP_EDIT_NEXT_ADDR, 64'h1000, 0, 64'h5000);
        chk_op("nosplit", 5, OP_UNLOCK, 64'h1000, 0, 0);

        dly = 1'b0;
        setup(64'h2000, 64'h2000, 64'h20, 64'h3000, 64'h3000, 64'h80, 64'h0, 0, 0, 0);
        stall_op = base + 2;
        send(64'h40);
        t = 0;
        while (!(lsu_req.val && n_ops == stall_op) && t < 100) begin
            @(negedge clk);
            t++;
        end
        snap = lsu_req;
        chk("bp_addr", snap.addr, 64'h2000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            assert (lsu_req === snap) else begin
                fails++;
                $error("FAIL bp_stable%0d got=%h exp=%h", i, lsu_req, snap);
            end
        end
        wait_rsp("walk", lat);
        chk("walk_ok", 64'(rsp_ok), 64'd1);
        chk("walk_addr", rsp_addr, 64'h3010);
        take_rsp();
        chk("walk_nops", 64'(n_ops - base), 64'd8);
        chk_op("walk", 3, OP_LOAD, 64'h3000, 0, 0);
        chk_op("walk", 4, OP_EDIT_SIZE_AND_NEXT_ADDR, 64'h3050, 64'h30, 0);
        chk_op("walk", 5, OP_EDIT_SIZE_AND_NEXT_ADDR, 64'h3000, 64'h50, 0);
        chk_op("walk", 6, OP_EDIT_NEXT_ADDR, 64'h2000, 0, 64'h3050);

        setup(64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(64'h20);
        wait_rsp("empty", lat);
        chk("empty_ok", 64'(rsp_ok), 64'd0);
        chk("empty_addr", rsp_addr, 64'd0);
        take_rsp();
        chk("empty_nops", 64'(n_ops - base), 64'd3);
        chk_op("empty", 2, OP_UNLOCK, 64'h1000, 0, 0);

        setup(64'h2000, 64'h2000, 64'h10, 64'h3000, 64'h3000, 64'h10, 64'h4000, 64'h4000, 64'h10, 64'h0);
        send(64'h10);
        wait_rsp("hops", lat);
        chk("hops_ok", 64'(rsp_ok), 64'd0);
        chk("hops_addr", rsp_addr, 64'd0);
        take_rsp();
        chk("hops_nops", 64'(n_ops - base), 64'd5);
        chk_op("hops", 3, OP_LOAD, 64'h3000, 0, 0);
        chk_op("hops", 4, OP_UNLOCK, 64'h1000, 0, 0);

        setup(64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(64'hFFFF_FFFF_FFFF_FFF0);
        wait_rsp("ovf", lat);
        chk("ovf_latency", 64'(lat), 64'd1);
        chk("ovf_ok", 64'(rsp_ok), 64'd0);
        chk("ovf_addr", rsp_addr, 64'd0);
        take_rsp();
        chk("ovf_nops", 64'(n_ops - base), 64'd0);
        base = n_ops;
        send(64'hFFFF_FFFF_FFFF_FFE8);
        wait_rsp("edge", lat);
        chk("edge_ok", 64'(rsp_ok), 64'd0);
        take_rsp();
        chk("edge_nops", 64'(n_ops - base), 64'd3);

        dly = 1'b1;
        setup(64'h2000, 64'h2000, 64'h20, 64'h3000, 64'h3000, 64'h80, 64'h0, 0, 0, 0);
        send(64'h40);
        t = 0;
        while (n_ops - base < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_rsp_addr", rsp_addr, 64'd0);
        chk("mid_rst_rsp_ok", 64'(rsp_ok), 64'd0);
        tests++;
        assert (lsu_req === '0) else begin
            fails++;
            $error("FAIL mid_rst_lsu got=%h exp=0", lsu_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_before = n_ops;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_unlock", 64'(n_ops - n_before), 64'd0);
        setup(64'h2000, 64'h2000, 64'h100, 64'h0, 0, 0, 0, 0, 0, 0);
        send(64'h20);
        wait_rsp("recover", lat);
        chk("recover_ok", 64'(rsp_ok), 64'd1);
        chk("recover_addr", rsp_addr, 64'h2010);
        take_rsp();
        chk("recover_nops", 64'(n_ops - base), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
